axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_pkg.sv | 29 ++
 rtl/AXI_define.svh | 10 +
 rtl/axi_sram_slave.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_pkg.sv
// Types and constants for the AXI-to-SRAM slave: FSM states, response codes and strobe expansion.
`include "AXI_define.svh"

package axi_sram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    R_ISSUE = 3'd1,
    R_DATA  = 3'd2,
    W_DATA  = 3'd3,
    W_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // Each byte strobe becomes eight active-low SRAM bit enables.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    bweb = '1;
    for (int k = 0; k < 4; k++) begin
      bweb[8*k +: 8] = strb[k] ? 8'h00 : 8'hFF;
    end
    return bweb;
  endfunction

endpackage

// File: rtl/AXI_define.svh
// Shared AXI field widths used by the SRAM slave and anything that connects to it.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH

`define AXI_IDS_BITS  8
`define AXI_ADDR_BITS 32
`define AXI_DATA_BITS 32
`define AXI_LEN_BITS  4

`endif

// File: rtl/axi_sram_slave.sv
// AXI3-style single-port SRAM slave, one outstanding transaction, INCR bursts of up to 16 words.
// Define AXI_SRAM_SLAVE_ERRCHK_EN to flag non-word SIZE / non-INCR BURST / misplaced WLAST as SLVERR.
`include "AXI_define.svh"

module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  // Every channel uses strict valid/ready: a beat transfers on a rising edge where both are high;
  // the sender holds payload stable while valid is high and ready is low.
  input  logic [`AXI_IDS_BITS-1:0] ARID,
  input  logic [31:0]              ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [`AXI_IDS_BITS-1:0] RID,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [`AXI_IDS_BITS-1:0] AWID,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [`AXI_IDS_BITS-1:0] BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic                     CEB,
  output logic                     WEB,
  output logic [ADDR_W-1:0]        A,
  output logic [31:0]              DI,
  output logic [31:0]              BWEB,
  input  logic [31:0]              DO,
  output state_t                   dbg_state
);

  state_t                   state, state_nxt;
  logic [`AXI_IDS_BITS-1:0] id_q;
  logic [ADDR_W-1:0]        addr_q, a_hold;
  logic [31:0]              di_hold;
  logic [3:0]               len_q, cnt_q;
  logic                     err_q, wlast_err_q;
  logic                     last_beat;
  logic                     err_set_r, err_set_w, wlast_bad;
  logic                     ar_rdy, aw_rdy, r_vld, w_rdy, b_vld;
  logic                     sram_rd, sram_wr;

  assign last_beat = (cnt_q == len_q);

`ifdef AXI_SRAM_SLAVE_ERRCHK_EN
  assign err_set_r = (ARSIZE != SIZE_WORD) || (ARBURST != BURST_INCR);
  assign err_set_w = (AWSIZE != SIZE_WORD) || (AWBURST != BURST_INCR);
  assign wlast_bad = (WLAST != last_beat);
  logic unused_ok;
  assign unused_ok = &{1'b0, ARADDR[31:ADDR_W+2], ARADDR[1:0], AWADDR[31:ADDR_W+2], AWADDR[1:0]};
`else
  assign err_set_r = 1'b0;
  assign err_set_w = 1'b0;
  assign wlast_bad = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, ARADDR[31:ADDR_W+2], ARADDR[1:0], AWADDR[31:ADDR_W+2], AWADDR[1:0],
                       ARSIZE, ARBURST, AWSIZE, AWBURST, WLAST};
`endif

  always_comb begin
    state_nxt = state;
    ar_rdy    = 1'b0;
    aw_rdy    = 1'b0;
    r_vld     = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    sram_rd   = 1'b0;
    sram_wr   = 1'b0;
    unique case (state)
      IDLE: begin
        aw_rdy = 1'b1;
        ar_rdy = ~AWVALID;
        if (AWVALID)      state_nxt = W_DATA;
        else if (ARVALID) state_nxt = R_ISSUE;
      end
      R_ISSUE: begin
        sram_rd   = ~err_q;
        state_nxt = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (RREADY) state_nxt = last_beat ? IDLE : R_ISSUE;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (WVALID) begin
          sram_wr = ~err_q;
          if (last_beat) state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (BREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences the bus and the SRAM immediately, not just after the next edge.
    if (!rst) begin
      ar_rdy  = 1'b0;
      aw_rdy  = 1'b0;
      r_vld   = 1'b0;
      w_rdy   = 1'b0;
      b_vld   = 1'b0;
      sram_rd = 1'b0;
      sram_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && AWVALID) begin
        id_q        <= AWID;
        addr_q      <= AWADDR[ADDR_W+1:2];
        len_q       <= AWLEN;
        cnt_q       <= '0;
        err_q       <= err_set_w;
        wlast_err_q <= 1'b0;
      end else if (state == IDLE && ARVALID) begin
        id_q        <= ARID;
        addr_q      <= ARADDR[ADDR_W+1:2];
        len_q       <= ARLEN;
        cnt_q       <= '0;
        err_q       <= err_set_r;
        wlast_err_q <= 1'b0;
      end
      if (state == R_DATA && RREADY && !last_beat) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (state == W_DATA && WVALID) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
        if (wlast_bad) wlast_err_q <= 1'b1;
      end
    end
  end

  // Address and write data stay parked on the SRAM pins between accesses.
  always_ff @(posedge clk) begin
    if (sram_rd || sram_wr) a_hold <= addr_q;
    if (sram_wr)            di_hold <= WDATA;
  end

  assign ARREADY   = ar_rdy;
  assign AWREADY   = aw_rdy;
  assign WREADY    = w_rdy;
  assign RVALID    = r_vld;
  assign BVALID    = b_vld;
  assign RID       = id_q;
  assign BID       = id_q;
  assign RDATA     = err_q ? 32'h0 : DO;
  assign RLAST     = r_vld & last_beat;
  assign RRESP     = (rst && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign BRESP     = (rst && (err_q || wlast_err_q)) ? RESP_SLVERR : RESP_OKAY;
  assign CEB       = ~(sram_rd | sram_wr);
  assign WEB       = ~sram_wr;
  assign BWEB      = sram_wr ? strb_to_bweb(WSTRB) : '1;
  assign A         = (sram_rd || sram_wr) ? addr_q : a_hold;
  assign DI        = sram_wr ? WDATA : di_hold;
  assign dbg_state = state;

endmodule
